alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
//  Registered, handshaked ALU-control stage between ID and EX. Maps {alu_op, op, funct3, funct7} to a 4-bit
//  ALU control covering all RV32I ops (incl. SLT/SLTU/SRA/LUI pass-through), flags illegal encodings, and,
//  when EN_M=1, dispatches RV32M ops to an external multi-cycle MDU, stalling until its fixed latency expires.
// PARAMETERS
//  ALUOP_WIDTH  3  width of alu_op instruction-type code from main decoder
//  OP_WIDTH     7  opcode width
//  F3_WIDTH     3  funct3 width
//  F7_WIDTH     7  funct7 width
//  CTRL_WIDTH   4  alu_ctrl width (>=4)
//  EN_M         1  1: accept RV32M (funct7=0000001, R-form); 0: flag them illegal
//  MDU_LATENCY  4  cycles from mdu_start to MDU result; legal range 1..15
// PORTS
//  clk         in   1            rising-edge clock
//  rst_n       in   1            asynchronous, active-low reset
//  flush       in   1            sync pipeline flush; kills held/in-flight op
//  in_valid    in   1            decode fields valid
//  in_ready    out  1            stage can accept this cycle
//  alu_op      in   ALUOP_WIDTH  instr_type_e from main decoder
//  op          in   OP_WIDTH     opcode
//  funct3      in   F3_WIDTH     funct3
//  funct7      in   F7_WIDTH     funct7
//  out_valid   out  1            registered outputs valid
//  out_ready   in   1            EX consumes outputs
//  alu_ctrl    out  CTRL_WIDTH   alu_ctrl_e
//  mdu_sel     out  1            result comes from MDU (M op)
//  mdu_op      out  3            M op = funct3 (MUL..REMU)
//  mdu_start   out  1            one-cycle pulse to MDU
//  illegal     out  1            unsupported encoding
// BEHAVIOUR
//  Reset: out_valid=0, alu_ctrl=ADD(0), mdu_sel=0, mdu_op=0, mdu_start=0, illegal=0, state=IDLE, count=0.
//  alu_ctrl: ADD 0,SUB 1,SLL 2,SLT 3,SLTU 4,XOR 5,SRL 6,SRA 7,OR 8,AND 9,PASSB 10; 11-15 reserved.
//  RIALU: f3 000 -> SUB iff op[5]&funct7[5] else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 -> SRA iff funct7[5] else SRL; 110 OR; 111 AND.
//  I(load)/S/U(auipc)/JALR/JAL -> ADD; U_LUI -> PASSB.
//  B: f3 000/001 SUB; 100/101 SLT; 110/111 SLTU; 010/011 illegal.
//  Illegal (out_valid still raised, alu_ctrl=ADD, mdu_sel=0): R-form funct7 not in {0x00,0x20,0x01};
//   funct7=0x20 with f3 not 000/101; I-form shift funct7 not 0x00/0x20; funct7=0x01 with EN_M=0.
//  Handshake: accept when in_valid&in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//   Outputs held stable while out_valid & !out_ready.
//  Non-M: accept at edge k -> out_valid=1 after edge k (latency 1).
//  M (op[5], funct7=0x01, EN_M=1): edge k: mdu_sel=1, mdu_op=funct3, mdu_start=1 for one cycle,
//   state IDLE->BUSY, count=MDU_LATENCY-1. Each BUSY cycle count--; at count==0 -> IDLE and out_valid=1.
//   out_valid rises after edge k+MDU_LATENCY-1 (MDU_LATENCY=1: same timing as non-M, no BUSY).
//  FSM: IDLE --accept M & MDU_LATENCY>1--> BUSY; BUSY --count==0--> IDLE (out_valid=1); BUSY --flush--> IDLE.
//  flush beats accept and consume: next edge out_valid=0, mdu_start=0, state=IDLE; in_ready low that cycle.
//  out_ready with in_valid same cycle: consume and accept together (back-to-back, no bubble).
//  Async reset mid-BUSY: immediate IDLE, all outputs to reset values; no result emitted.
//  count width $clog2(MDU_LATENCY+1); never wraps (loaded only in IDLE).
// STRUCTURE
//  alu_pkg: instr_type_e (RIALU 0..J_JAL 7), alu_ctrl_e, mdu_op_e, stage_state_e {IDLE,BUSY}, F7_* consts.
//  Sub-module alu_ctrl_comb: pure combinational {alu_op,op,funct3,funct7}->{alu_ctrl,mdu_sel,illegal}.
//  Top: output register, handshake logic, BUSY counter FSM.
// TESTING
//  R sub: alu_op=0,op=0x33,f3=0,f7=0x20,out_ready=1 -> next cycle out_valid=1, alu_ctrl=1, illegal=0.
//  addi f7 garbage: op=0x13,f3=0,f7=0x20 -> alu_ctrl=0 (ADD); srai op=0x13,f3=5,f7=0x20 -> 7.
//  MUL, MDU_LATENCY=4: op=0x33,f3=0,f7=0x01 -> mdu_start 1 cycle, in_ready=0 3 cycles, out_valid after 4th edge.
//  Backpressure: out_ready=0 for 3 cycles after valid -> outputs stable, in_ready=0; then out_ready=1 + new in_valid -> no bubble.
//  flush during BUSY cycle 2 -> next edge out_valid=0, state IDLE, in_ready=1; rst_n low mid-BUSY -> all reset values.
//  Illegal: B f3=2 -> illegal=1, alu_ctrl=0; EN_M=0 with f7=0x01 -> illegal=1, mdu_start never pulses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ID->EX ALU-control stage.
package alu_pkg;

  // Instruction class from the main decoder
  typedef enum logic [2:0] {
    IT_RIALU    = 3'd0,
    IT_I_LOAD   = 3'd1,
    IT_S_STORE  = 3'd2,
    IT_B_BRANCH = 3'd3,
    IT_U_LUI    = 3'd4,
    IT_U_AUIPC  = 3'd5,
    IT_I_JALR   = 3'd6,
    IT_J_JAL    = 3'd7
  } instr_type_e;

  // ALU operation select; codes 11..15 are reserved
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  // RV32M operation, equal to funct3
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } stage_state_e;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // Register/immediate ALU op from funct3; alt selects SUB/SRA variants
  function automatic alu_ctrl_e rialu_ctrl(input logic [2:0] f3, input logic alt);
    alu_ctrl_e c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      3'b111:  c = ALU_AND;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_comb.sv
// Pure combinational mapping of decode fields to ALU control, MDU select and illegal flag.
module alu_ctrl_comb
  import alu_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int OP_WIDTH    = 7,
  parameter int F3_WIDTH    = 3,
  parameter int F7_WIDTH    = 7,
  parameter bit EN_M        = 1'b1
) (
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [F3_WIDTH-1:0]    funct3,
  input  logic [F7_WIDTH-1:0]    funct7,
  output alu_ctrl_e              alu_ctrl,
  output logic                   mdu_sel,
  output logic                   illegal
);

  logic [2:0] f3_s;
  logic [6:0] f7_s;
  logic       r_form_s;
  alu_ctrl_e  ctrl_s;
  logic       mdu_s;
  logic       ill_s;
  logic       unused_op_s;

  assign f3_s        = funct3[2:0];
  assign f7_s        = funct7[6:0];
  assign r_form_s    = op[5];
  assign unused_op_s = ^{op[OP_WIDTH-1:6], op[4:0]};

  // Decode instruction class and function fields; illegal encodings fall back to ADD
  always_comb begin
    ctrl_s = ALU_ADD;
    mdu_s  = 1'b0;
    ill_s  = 1'b0;
    case (alu_op)
      IT_RIALU: begin
        if (r_form_s) begin
          if (f7_s == F7_BASE) begin
            ctrl_s = rialu_ctrl(f3_s, 1'b0);
          end else if (f7_s == F7_ALT) begin
            if ((f3_s == 3'b000) || (f3_s == 3'b101)) begin
              ctrl_s = rialu_ctrl(f3_s, 1'b1);
            end else begin
              ill_s = 1'b1;
            end
          end else if (f7_s == F7_MULDIV) begin
            if (EN_M) begin
              mdu_s = 1'b1;
            end else begin
              ill_s = 1'b1;
            end
          end else begin
            ill_s = 1'b1;
          end
        end else begin
          // Immediate form: funct7 only carries meaning for shifts
          if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
            if ((f7_s == F7_BASE) || (f7_s == F7_ALT)) begin
              ctrl_s = rialu_ctrl(f3_s, f7_s[5]);
            end else begin
              ill_s = 1'b1;
            end
          end else begin
            ctrl_s = rialu_ctrl(f3_s, 1'b0);
          end
        end
      end
      IT_B_BRANCH: begin
        case (f3_s)
          3'b000, 3'b001: ctrl_s = ALU_SUB;
          3'b100, 3'b101: ctrl_s = ALU_SLT;
          3'b110, 3'b111: ctrl_s = ALU_SLTU;
          default:        ill_s  = 1'b1;
        endcase
      end
      IT_U_LUI:                                            ctrl_s = ALU_PASSB;
      IT_I_LOAD, IT_S_STORE, IT_U_AUIPC, IT_I_JALR, IT_J_JAL: ctrl_s = ALU_ADD;
      default:                                             ctrl_s = ALU_ADD;
    endcase
  end

  assign alu_ctrl = ctrl_s;
  assign mdu_sel  = mdu_s;
  assign illegal  = ill_s;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered, handshaked ALU-control stage between ID and EX with optional multi-cycle MDU dispatch.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int ALUOP_WIDTH = 3,
  parameter int OP_WIDTH    = 7,
  parameter int F3_WIDTH    = 3,
  parameter int F7_WIDTH    = 7,
  parameter int CTRL_WIDTH  = 4,
  parameter bit EN_M        = 1'b1,
  parameter int MDU_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [F3_WIDTH-1:0]    funct3,
  input  logic [F7_WIDTH-1:0]    funct7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  alu_ctrl,
  output logic                   mdu_sel,
  output logic [2:0]             mdu_op,
  output logic                   mdu_start,
  output logic                   illegal
);

  localparam int                   CNT_WIDTH   = $clog2(MDU_LATENCY + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD    = CNT_WIDTH'(MDU_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic                 MULTI_CYCLE = (MDU_LATENCY > 1);

  alu_ctrl_e              dec_ctrl_s;
  logic                   dec_mdu_s;
  logic                   dec_ill_s;

  stage_state_e           state_r, state_next_s;
  logic [CNT_WIDTH-1:0]   count_r, count_next_s;

  logic                   out_valid_r, out_valid_next_s;
  alu_ctrl_e              alu_ctrl_r, alu_ctrl_next_s;
  logic                   mdu_sel_r, mdu_sel_next_s;
  logic [2:0]             mdu_op_r, mdu_op_next_s;
  logic                   mdu_start_r, mdu_start_next_s;
  logic                   illegal_r, illegal_next_s;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   consume_s;
  logic                   last_busy_s;

  alu_ctrl_comb #(
    .ALUOP_WIDTH (ALUOP_WIDTH),
    .OP_WIDTH    (OP_WIDTH),
    .F3_WIDTH    (F3_WIDTH),
    .F7_WIDTH    (F7_WIDTH),
    .EN_M        (EN_M)
  ) u_ctrl (
    .alu_op   (alu_op),
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_ctrl_s),
    .mdu_sel  (dec_mdu_s),
    .illegal  (dec_ill_s)
  );

  // A held result blocks intake unless EX takes it this cycle; flush always blocks
  assign in_ready_s  = !flush && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign consume_s   = out_valid_r && out_ready;
  assign last_busy_s = (state_r == ST_BUSY) && (count_r <= CNT_ONE);

  // State and latency counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // Next-state: enter BUSY on a multi-cycle M accept, leave when the count runs out or on flush
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    if (flush) begin
      state_next_s = ST_IDLE;
      count_next_s = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && dec_mdu_s && MULTI_CYCLE) begin
            state_next_s = ST_BUSY;
            count_next_s = CNT_LOAD;
          end else begin
            state_next_s = ST_IDLE;
            count_next_s = count_r;
          end
        end
        ST_BUSY: begin
          if (last_busy_s) begin
            state_next_s = ST_IDLE;
            count_next_s = CNT_ZERO;
          end else begin
            state_next_s = ST_BUSY;
            count_next_s = count_r - CNT_ONE;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          count_next_s = CNT_ZERO;
        end
      endcase
    end
  end

  // Next values of the result register; fields stay put while a result waits for EX
  always_comb begin
    out_valid_next_s = out_valid_r;
    alu_ctrl_next_s  = alu_ctrl_r;
    mdu_sel_next_s   = mdu_sel_r;
    mdu_op_next_s    = mdu_op_r;
    illegal_next_s   = illegal_r;
    mdu_start_next_s = 1'b0;
    if (flush) begin
      out_valid_next_s = 1'b0;
      alu_ctrl_next_s  = ALU_ADD;
      mdu_sel_next_s   = 1'b0;
      mdu_op_next_s    = 3'b000;
      illegal_next_s   = 1'b0;
    end else if (state_r == ST_BUSY) begin
      out_valid_next_s = last_busy_s;
    end else if (accept_s) begin
      alu_ctrl_next_s  = dec_ctrl_s;
      mdu_sel_next_s   = dec_mdu_s;
      mdu_op_next_s    = dec_mdu_s ? funct3[2:0] : 3'b000;
      illegal_next_s   = dec_ill_s;
      mdu_start_next_s = dec_mdu_s;
      out_valid_next_s = !(dec_mdu_s && MULTI_CYCLE);
    end else if (consume_s) begin
      out_valid_next_s = 1'b0;
    end else begin
      out_valid_next_s = out_valid_r;
    end
  end

  // Result output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      alu_ctrl_r  <= ALU_ADD;
      mdu_sel_r   <= 1'b0;
      mdu_op_r    <= 3'b000;
      mdu_start_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      out_valid_r <= out_valid_next_s;
      alu_ctrl_r  <= alu_ctrl_next_s;
      mdu_sel_r   <= mdu_sel_next_s;
      mdu_op_r    <= mdu_op_next_s;
      mdu_start_r <= mdu_start_next_s;
      illegal_r   <= illegal_next_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign alu_ctrl  = CTRL_WIDTH'(alu_ctrl_r);
  assign mdu_sel   = mdu_sel_r;
  assign mdu_op    = mdu_op_r;
  assign mdu_start = mdu_start_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage (EN_M=1 and EN_M=0 instances, MDU_LATENCY=4).
module tb_alu_decode_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [2:0] alu_op;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       out_ready;

  logic       in_ready, out_valid, mdu_sel, mdu_start, illegal;
  logic [3:0] alu_ctrl;
  logic [2:0] mdu_op;

  logic       nm_in_ready, nm_out_valid, nm_mdu_sel, nm_mdu_start, nm_illegal;
  logic [3:0] nm_alu_ctrl;
  logic [2:0] nm_mdu_op;

  int checks = 0;
  int errors = 0;
  int nm_starts = 0;

  alu_decode_stage #(.EN_M(1'b1), .MDU_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl), .mdu_sel(mdu_sel),
    .mdu_op(mdu_op), .mdu_start(mdu_start), .illegal(illegal)
  );

  alu_decode_stage #(.EN_M(1'b0), .MDU_LATENCY(4)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
    .out_valid(nm_out_valid), .out_ready(out_ready), .alu_ctrl(nm_alu_ctrl), .mdu_sel(nm_mdu_sel),
    .mdu_op(nm_mdu_op), .mdu_start(nm_mdu_start), .illegal(nm_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count any MDU start pulse from the instance built without RV32M
  always @(posedge clk) begin
    if (nm_mdu_start) nm_starts++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    alu_op   = a;
    op       = o;
    funct3   = f3;
    funct7   = f7;
    in_valid = 1'b1;
  endtask

  // One back-to-back non-M transaction with out_ready high
  task automatic vec(input string tag, input logic [2:0] a, input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [3:0] exp_ctrl, input logic exp_ill);
    drive(a, o, f3, f7);
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    tick();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_ctrl"}, alu_ctrl, exp_ctrl);
    chk({tag, "_ill"}, illegal, exp_ill);
    chk({tag, "_msel"}, mdu_sel, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 3'd0; op = 7'h00; funct3 = 3'd0; funct7 = 7'h00;

    // Reset state
    tick(); tick();
    chk("rst_vld", out_valid, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_msel", mdu_sel, 0);
    chk("rst_mop", mdu_op, 0);
    chk("rst_mst", mdu_start, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Decode table, back-to-back
    vec("r_sub",  3'd0, 7'h33, 3'd0, 7'h20, 4'd1,  1'b0);
    vec("i_addi", 3'd0, 7'h13, 3'd0, 7'h20, 4'd0,  1'b0);
    vec("i_srai", 3'd0, 7'h13, 3'd5, 7'h20, 4'd7,  1'b0);
    vec("i_srli", 3'd0, 7'h13, 3'd5, 7'h00, 4'd6,  1'b0);
    vec("r_add",  3'd0, 7'h33, 3'd0, 7'h00, 4'd0,  1'b0);
    vec("r_sll",  3'd0, 7'h33, 3'd1, 7'h00, 4'd2,  1'b0);
    vec("r_slt",  3'd0, 7'h33, 3'd2, 7'h00, 4'd3,  1'b0);
    vec("r_sltu", 3'd0, 7'h33, 3'd3, 7'h00, 4'd4,  1'b0);
    vec("r_xor",  3'd0, 7'h33, 3'd4, 7'h00, 4'd5,  1'b0);
    vec("r_srl",  3'd0, 7'h33, 3'd5, 7'h00, 4'd6,  1'b0);
    vec("r_sra",  3'd0, 7'h33, 3'd5, 7'h20, 4'd7,  1'b0);
    vec("r_or",   3'd0, 7'h33, 3'd6, 7'h00, 4'd8,  1'b0);
    vec("r_and",  3'd0, 7'h33, 3'd7, 7'h00, 4'd9,  1'b0);
    vec("i_slti", 3'd0, 7'h13, 3'd2, 7'h55, 4'd3,  1'b0);
    vec("lui",    3'd4, 7'h37, 3'd0, 7'h00, 4'd10, 1'b0);
    vec("auipc",  3'd5, 7'h17, 3'd0, 7'h00, 4'd0,  1'b0);
    vec("load",   3'd1, 7'h03, 3'd2, 7'h00, 4'd0,  1'b0);
    vec("store",  3'd2, 7'h23, 3'd2, 7'h00, 4'd0,  1'b0);
    vec("jalr",   3'd6, 7'h67, 3'd0, 7'h00, 4'd0,  1'b0);
    vec("jal",    3'd7, 7'h6f, 3'd0, 7'h00, 4'd0,  1'b0);
    vec("beq",    3'd3, 7'h63, 3'd0, 7'h00, 4'd1,  1'b0);
    vec("bge",    3'd3, 7'h63, 3'd5, 7'h00, 4'd3,  1'b0);
    vec("bltu",   3'd3, 7'h63, 3'd6, 7'h00, 4'd4,  1'b0);
    vec("b_f3_2", 3'd3, 7'h63, 3'd2, 7'h00, 4'd0,  1'b1);
    vec("r_f7bad",3'd0, 7'h33, 3'd0, 7'h40, 4'd0,  1'b1);
    vec("r_f7alt",3'd0, 7'h33, 3'd1, 7'h20, 4'd0,  1'b1);
    vec("i_shbad",3'd0, 7'h13, 3'd1, 7'h10, 4'd0,  1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain_vld", out_valid, 0);

    // MUL with 4-cycle MDU latency
    drive(3'd0, 7'h33, 3'd0, 7'h01);
    tick();
    in_valid = 1'b0;
    chk("mul_start", mdu_start, 1);
    chk("mul_sel", mdu_sel, 1);
    chk("mul_op", mdu_op, 0);
    chk("mul_vld0", out_valid, 0);
    chk("mul_rdy0", in_ready, 0);
    tick();
    chk("mul_start1", mdu_start, 0);
    chk("mul_vld1", out_valid, 0);
    chk("mul_rdy1", in_ready, 0);
    tick();
    chk("mul_vld2", out_valid, 0);
    chk("mul_rdy2", in_ready, 0);
    tick();
    chk("mul_vld3", out_valid, 1);
    chk("mul_sel3", mdu_sel, 1);
    chk("mul_ill3", illegal, 0);
    chk("mul_rdy3", in_ready, 1);
    tick();
    chk("mul_drain", out_valid, 0);

    // Backpressure: result held, then consume and accept together
    out_ready = 1'b0;
    drive(3'd0, 7'h33, 3'd4, 7'h00);
    tick();
    chk("bp_vld", out_valid, 1);
    chk("bp_ctrl", alu_ctrl, 5);
    drive(3'd0, 7'h33, 3'd7, 7'h00);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", in_ready, 0);
      tick();
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_ctrl", alu_ctrl, 5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_go", in_ready, 1);
    tick();
    chk("bp_next_vld", out_valid, 1);
    chk("bp_next_ctrl", alu_ctrl, 9);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);

    // Flush during the second BUSY cycle of REMU
    drive(3'd0, 7'h33, 3'd7, 7'h01);
    tick();
    in_valid = 1'b0;
    chk("fl_op", mdu_op, 7);
    chk("fl_start", mdu_start, 1);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_rdy_lo", in_ready, 0);
    tick();
    chk("fl_vld", out_valid, 0);
    chk("fl_start0", mdu_start, 0);
    flush = 1'b0;
    #1;
    chk("fl_rdy_hi", in_ready, 1);
    tick(); tick(); tick();
    chk("fl_no_res", out_valid, 0);

    // Asynchronous reset while BUSY with DIV
    drive(3'd0, 7'h33, 3'd4, 7'h01);
    tick();
    in_valid = 1'b0;
    chk("ar_op", mdu_op, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_msel", mdu_sel, 0);
    chk("ar_mop", mdu_op, 0);
    chk("ar_mst", mdu_start, 0);
    chk("ar_rdy", in_ready, 1);
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("ar_no_res", out_valid, 0);

    // EN_M=0: RV32M encoding is illegal and never starts the MDU
    drive(3'd0, 7'h33, 3'd0, 7'h01);
    tick();
    in_valid = 1'b0;
    chk("nm_vld", nm_out_valid, 1);
    chk("nm_ill", nm_illegal, 1);
    chk("nm_ctrl", nm_alu_ctrl, 0);
    chk("nm_msel", nm_mdu_sel, 0);
    tick(); tick(); tick(); tick();
    chk("nm_starts", nm_starts, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
